sensor_fifo_arbiter: RTL
========================

Name: sensor_fifo_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of the sensor FIFO among NUM_REQ sensor requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter grants one requester at a time for a burst of up to BURST_LEN words, honours fifo_full back-pressure, and drives write_command/write_data.
- Sits between the sensor front-ends and the FIFO write side, in the FIFO write-clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BURST_LEN, 4, maximum words per grant (1..15)
DATA_WIDTH, 32, word width; matches FIFO write_data
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  input  1  single clock; all state on rising edge
n_rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a word on req_data slice i
req_data  input  NUM_REQ*DATA_WIDTH  packed words; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  word of requester i accepted this cycle when valid&ready
fifo_full  input  1  FIFO full flag; no write may be issued while high
write_command  output  1  FIFO write strobe, one word per cycle
write_data  output  DATA_WIDTH  word written to FIFO
grant_id  output  ID_W  index of the currently granted requester (registered)
busy  output  1  high while in BURST

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0. Outputs req_ready=0, write_command=0, write_data=0, busy=0. Any burst in progress is abandoned; no write is issued.
- State register: IDLE or BURST.
- Registered state: grant_id, rr_ptr (ID_W, next priority start), beat_cnt (4 bits).
- Selection function: first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- IDLE:
  - req_ready=0, write_command=0.
  - If any req_valid: next cycle state=BURST, grant_id=selected, beat_cnt=0, rr_ptr=selected+1 mod NUM_REQ.
  - Arbitration latency is one cycle from valid to first possible accept.
- BURST:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits are 0.
  - Transfer (combinational, same cycle) = req_valid[grant_id] & !fifo_full.
  - On a transfer: write_command=1, write_data=req_data[grant_id], beat_cnt increments.
  - No transfer: write_command=0, write_data=0.
- Burst end occurs on either:
  - (a) a transfer with beat_cnt==BURST_LEN-1; or
  - (b) a cycle with fifo_full=0 and req_valid[grant_id]=0.
- While fifo_full=1, the burst never ends: grant_id and beat_cnt hold even if req_valid drops.
- At burst end, re-arbitrate in the same cycle. The search starts at rr_ptr (= old grant+1), so the outgoing requester is considered last.
  - If any req_valid: remain in BURST with the new grant, beat_cnt=0, rr_ptr updated. Bursts run back-to-back with no idle cycle.
  - Otherwise go to IDLE.
  - For end condition (a), the req_valid sampled for the outgoing requester is its current value; it may be re-granted if it is the only one valid.
- Requester rule: req_data must hold stable while valid=1 and ready=0. The arbiter does not register data; write_data is a combinational mux.
- Throughput: at most one write per cycle. There is never a write while fifo_full=1. A full sustained stream writes every cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,..., with BURST_LEN words each.
- grant_id holds its last value in IDLE. busy = (state==BURST).

Test Plan:
1. Single requester: req_valid[1]=1 with words 0xA1,0xA2,0xA3, then drop -> grant_id=1 and busy one cycle after valid; write_command high 3 consecutive cycles with write_data A1,A2,A3; the cycle valid drops -> IDLE.
2. All 4 valid continuously, BURST_LEN=4, fifo_full=0 -> grants 0,1,2,3,0 in order; 4 writes each; 16 writes in 16 consecutive cycles after first grant; no gap between bursts.
3. Requester 0 bursting; fifo_full=1 after 2 words for 3 cycles (valid dropped in middle cycle, restored) -> req_ready/write_command 0 for 3 cycles, grant_id and beat_cnt hold, remaining 2 words written, then rotate.
4. Only requester 2 valid with 10 words -> bursts of 4,4,2 with grant_id=2 throughout, writes back-to-back, IDLE after the 10th word.
5. Reset asserted mid-burst after 1 word -> outputs 0 immediately (asynchronous); after release, state=IDLE; with req 1 and 3 valid, requester 1 is granted first (rr_ptr=0).
6. Requesters 0 and 3 valid, requester 0 finishes a full burst with valid still high -> next grant is 3; requester 0 is re-granted only after requester 3's burst ends.

Source files
------------

// File: rtl/sensor_fifo_arbiter_if.sv
// Write-side bus between the sensor requesters and the FIFO, as seen by the arbiter.
// The master modport is the arbiter; the slave modport is the requester/FIFO side.
interface sensor_fifo_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          write_command;
  logic [DATA_WIDTH-1:0]         write_data;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, write_command, write_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, write_command, write_data, grant_id, busy
  );
endinterface

// File: rtl/sensor_fifo_arbiter.sv
// Round-robin burst arbiter sharing the sensor FIFO write port among NUM_REQ requesters.
// Write data is a combinational mux of the granted requester's word; nothing is buffered.
module sensor_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sensor_fifo_arbiter_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, next_state;
  logic [ID_W-1:0]       grant_id, rr_ptr, sel_id, sel_next_ptr;
  logic [3:0]            beat_cnt;
  logic                  any_valid, hi_found;
  logic [ID_W-1:0]       hi_id, lo_id;
  logic                  granted_valid, xfer, burst_end, load_grant;
  logic [DATA_WIDTH-1:0] granted_word;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    any_valid = 1'b0;
    hi_found  = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
        any_valid = 1'b1;
        lo_id     = ID_W'(i);
      end
    end
    sel_id       = hi_found ? hi_id : lo_id;
    sel_next_ptr = (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + 1'b1;
  end

  always_comb begin
    granted_valid = 1'b0;
    granted_word  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        granted_valid = bus.req_valid[k];
        granted_word  = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A full FIFO freezes the burst: neither end condition can fire while it is high.
  assign xfer       = (state == BURST) && granted_valid && !bus.fifo_full;
  assign burst_end  = (state == BURST) &&
                      ((xfer && (beat_cnt == 4'(BURST_LEN-1))) ||
                       (!bus.fifo_full && !granted_valid));
  assign load_grant = any_valid && ((state == IDLE) || burst_end);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= next_state;
      if (load_grant) begin
        grant_id <= sel_id;
        rr_ptr   <= sel_next_ptr;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = BURST;
      BURST:   if (burst_end) next_state = any_valid ? BURST : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.write_command = xfer;
    bus.write_data    = xfer ? granted_word : '0;
    bus.busy          = (state == BURST);
    if (state == BURST) begin
      bus.req_ready[grant_id] = !bus.fifo_full;
    end
  end

  assign bus.grant_id = grant_id;

endmodule
